// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter.
// Holds FSM/grant enums and line geometry helpers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INST_BUSY,
    DATA_BUSY,
    RESPOND
  } arb_state_t;

  typedef enum logic {
    GRANT_INST,
    GRANT_DATA
  } arb_grant_t;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  // Byte-offset bits inside one cache line.
  function automatic int line_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Merges I-side and D-side line requests onto one memory port.
// One transaction at a time, round-robin on contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_read,
  input  logic [ADDR_W-1:0] inst_address,
  output logic              inst_resp,
  output logic [LINE_W-1:0] inst_rdata,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [LINE_W-1:0] data_wdata,
  output logic              data_resp,
  output logic [LINE_W-1:0] data_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam int OFF_W = line_off_w(LINE_W);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((64'd1 << OFF_W) - 64'd1);

  arb_state_t state;
  arb_grant_t last_grant;
  logic       is_write;

  logic              inst_pend;
  logic              data_pend;
  logic              pick_data;
  logic [ADDR_W-1:0] inst_line;
  logic [ADDR_W-1:0] data_line;

  assign inst_pend = inst_read;
  assign data_pend = data_read | data_write;
  assign inst_line = inst_address & ~OFF_MASK;
  assign data_line = data_address & ~OFF_MASK;

  // Data wins when alone or when inst was served last.
  assign pick_data = data_pend &
    (~inst_pend | (last_grant == GRANT_INST));

  // Arbitration FSM with registered strobes, resps and line capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= GRANT_INST;
      is_write     <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      inst_resp    <= 1'b0;
      data_resp    <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      inst_resp <= 1'b0;
      data_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_data) begin
            state        <= DATA_BUSY;
            last_grant   <= GRANT_DATA;
            is_write     <= data_write;
            pmem_read    <= ~data_write;
            pmem_write   <= data_write;
            pmem_address <= data_line;
            pmem_wdata   <= data_wdata;
          end else if (inst_pend) begin
            state        <= INST_BUSY;
            last_grant   <= GRANT_INST;
            is_write     <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= inst_line;
          end
        end
        INST_BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            inst_rdata <= pmem_rdata;
            inst_resp  <= 1'b1;
            state      <= RESPOND;
          end
        end
        DATA_BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (!is_write) data_rdata <= pmem_rdata;
            data_resp  <= 1'b1;
            state      <= RESPOND;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read and write together from the D-side is a requester bug.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(data_read && data_write));
    end
  end

endmodule
